cpu_flag_ctrl: RTL and testbench
================================

CPU_FLAG_CTRL -- requirements
Module: cpu_flag_ctrl

Interface
REQ-001 The block SHALL have parameter STACK_DEPTH, default 4, giving the number of flag-save stack entries (legal range 2..16).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports ALU_C, ALU_Z, ALU_B, input, 1 bit each: carry, zero and borrow produced by the ALU.
REQ-005 The block SHALL have port FLAG_WE, input, 1 bit: load ALU flags at the next edge.
REQ-006 The block SHALL have port FLAG_CLR, input, 1 bit: clear C, Z and B at the next edge.
REQ-007 The block SHALL have ports PUSH and POP, input, 1 bit each: save flags to, or restore flags from, the stack.
REQ-008 The block SHALL have port COND_REQ, input, 1 bit: request a branch-condition evaluation.
REQ-009 The block SHALL have port COND, input, 3 bits: the condition code sampled with COND_REQ.
REQ-010 The block SHALL have ports C, Z, B, output, 1 bit each: the architectural flags, driven from registers.
REQ-011 The block SHALL have ports COND_VALID and COND_TRUE, output, 1 bit each: the evaluation strobe and its result.
REQ-012 The block SHALL have ports STK_FULL, STK_EMPTY and STK_ERR, output, 1 bit each: stack full, stack empty, and sticky overflow/underflow.

Function
REQ-013 Flag-update priority per edge SHALL be POP restore > FLAG_CLR > FLAG_WE > hold.
REQ-014 PUSH SHALL store the pre-edge {C,Z,B} when the stack is not full; a concurrent FLAG_WE still updates the flags.
REQ-015 POP SHALL load {C,Z,B} from the top entry when the stack is not empty, overriding FLAG_CLR and FLAG_WE in that cycle.
REQ-016 PUSH and POP asserted together SHALL leave the stack, the pointer and STK_ERR unchanged; FLAG_CLR and FLAG_WE then apply normally.
REQ-017 PUSH when full, or POP when empty, SHALL be ignored and SHALL set STK_ERR, which stays set until RST.
REQ-018 STK_FULL and STK_EMPTY SHALL be registered and SHALL reflect the entry count after each edge.
REQ-019 The evaluator FSM SHALL have states IDLE and EVAL; COND_REQ=1 moves to or stays in EVAL, and COND_REQ=0 moves to IDLE.
REQ-020 In EVAL, COND_VALID SHALL be 1 for exactly the cycle following each sampled request; back-to-back requests SHALL give back-to-back strobes.
REQ-021 COND_TRUE SHALL be evaluated on the flags as updated at the sampling edge (a same-cycle FLAG_WE, CLR or POP is forwarded), and SHALL be 0 whenever COND_VALID=0.
REQ-022 COND encoding SHALL be: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101 B, 110 !B, 111 never.
REQ-023 Stack pointer width SHALL be clog2(STACK_DEPTH)+1, and the pointer SHALL never wrap.

Reset
REQ-024 RST SHALL, at the edge, set C=Z=B=0, COND_VALID=COND_TRUE=0, STK_ERR=0, STK_FULL=0, STK_EMPTY=1, the FSM to IDLE and the pointer to 0.
REQ-025 RST SHALL override all concurrent inputs, including during EVAL or a PUSH/POP; stack entry contents need not be cleared.

Configuration
REQ-026 With macro CPU_FLAG_STACK_EN defined, the stack and REQ-014..REQ-018 SHALL be implemented as specified.
REQ-027 Without CPU_FLAG_STACK_EN, no stack storage SHALL be built, PUSH and POP SHALL be ignored, and STK_EMPTY=1, STK_FULL=0 and STK_ERR=0 SHALL be constant.

Structure
REQ-028 Package cpu_flag_pkg SHALL hold the COND code constants, the flag vector width (3) and the bit indices C=2, Z=1, B=0.
REQ-029 The LIFO SHALL be sub-module cpu_flag_stack, instantiated only under CPU_FLAG_STACK_EN.

Verification
REQ-030 Reset test: assert RST during EVAL with PUSH=1 -> next cycle C=Z=B=0, COND_VALID=0, STK_EMPTY=1, STK_ERR=0.
REQ-031 Forwarding test: ALU_Z=1 with FLAG_WE=1, COND_REQ=1 and COND=001 in the same cycle -> next cycle Z=1, COND_VALID=1, COND_TRUE=1.
REQ-032 Save/restore test: with flags {1,0,1}, PUSH; then FLAG_CLR; then POP with FLAG_WE=1 and ALU={0,1,0} -> flags {1,0,1} and STK_EMPTY=1.
REQ-033 Boundary test (STACK_DEPTH=4): 5 PUSH -> STK_FULL=1 after the 4th and STK_ERR=1 after the 5th; then 5 POP -> the 4th restores the first-pushed value and STK_EMPTY=1, STK_ERR stays 1.
REQ-034 Simultaneous test: PUSH+POP with FLAG_CLR=1 at depth 2 -> depth stays 2, flags become 0, STK_ERR unchanged.
REQ-035 Configuration test: build without CPU_FLAG_STACK_EN; toggle PUSH and POP -> STK_EMPTY=1, STK_ERR=0, flags follow only FLAG_WE and FLAG_CLR.

Source files
------------

// File: rtl/cpu_flag_pkg.sv
// cpu_flag_pkg: flag vector layout, condition codes and the condition evaluator shared by the flag block
package cpu_flag_pkg;
  localparam int FLAG_W = 3;
  localparam int IDX_C  = 2;
  localparam int IDX_Z  = 1;
  localparam int IDX_B  = 0;
  typedef logic [FLAG_W-1:0] flags_t;
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_Z  = 3'b001;
  localparam logic [2:0] COND_NZ = 3'b010;
  localparam logic [2:0] COND_C  = 3'b011;
  localparam logic [2:0] COND_NC = 3'b100;
  localparam logic [2:0] COND_B  = 3'b101;
  localparam logic [2:0] COND_NB = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;
  function automatic logic cond_eval(input logic [2:0] cond, input flags_t f);
    return cond == COND_AL ? 1'b1 :
           cond == COND_Z  ? f[IDX_Z] :
           cond == COND_NZ ? ~f[IDX_Z] :
           cond == COND_C  ? f[IDX_C] :
           cond == COND_NC ? ~f[IDX_C] :
           cond == COND_B  ? f[IDX_B] :
           cond == COND_NB ? ~f[IDX_B] : 1'b0;
  endfunction
endpackage

// File: rtl/cpu_flag_stack.sv
// cpu_flag_stack: non-wrapping LIFO of flag vectors with registered full/empty and sticky misuse error
// Ports: CLK/RST clock and sync active-high reset; push_i/pop_i requests; din_i value to save;
//        dout_o top entry; pop_ok_o restore accepted this cycle; full_o/empty_o/err_o status.
module cpu_flag_stack
  import cpu_flag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   push_i,
  input  logic   pop_i,
  input  flags_t din_i,
  output flags_t dout_o,
  output logic   pop_ok_o,
  output logic   full_o,
  output logic   empty_o,
  output logic   err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  flags_t mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] top_idx;
  logic full_q, empty_q, err_q, err_d, push_ok;
  // push and pop together cancel: neither moves the pointer nor counts as misuse
  always_comb begin
    push_ok  = push_i & ~pop_i & ~full_q;
    pop_ok_o = pop_i & ~push_i & ~empty_q;
    err_d    = err_q | (push_i & ~pop_i & full_q) | (pop_i & ~push_i & empty_q);
    ptr_d    = push_ok ? ptr_q + PW'(1) : pop_ok_o ? ptr_q - PW'(1) : ptr_q;
  end
  assign top_idx = AW'(ptr_q - PW'(1));
  assign dout_o  = mem_q[top_idx];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign err_o   = err_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      full_q  <= ptr_d == PW'(DEPTH);
      empty_q <= ptr_d == '0;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge CLK)
    if (push_ok && !RST) mem_q[ptr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/cpu_flag_ctrl.sv
// cpu_flag_ctrl: C/Z/B flag register with optional save stack (macro CPU_FLAG_STACK_EN) and branch-condition evaluator
// Ports: CLK/RST clock and sync active-high reset; ALU_C/ALU_Z/ALU_B new flags; FLAG_WE load; FLAG_CLR clear;
//        PUSH/POP stack save/restore; COND_REQ/COND evaluation request; C/Z/B flags;
//        COND_VALID/COND_TRUE evaluation result; STK_FULL/STK_EMPTY/STK_ERR stack status.
module cpu_flag_ctrl
  import cpu_flag_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ALU_C,
  input  logic       ALU_Z,
  input  logic       ALU_B,
  input  logic       FLAG_WE,
  input  logic       FLAG_CLR,
  input  logic       PUSH,
  input  logic       POP,
  input  logic       COND_REQ,
  input  logic [2:0] COND,
  output logic       C,
  output logic       Z,
  output logic       B,
  output logic       COND_VALID,
  output logic       COND_TRUE,
  output logic       STK_FULL,
  output logic       STK_EMPTY,
  output logic       STK_ERR
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EVAL = 1'b1;
  flags_t flags_q, flags_d, stk_dout;
  logic [0:0] state_q, state_d;
  logic cond_true_q, cond_true_d, pop_ok;
`ifdef CPU_FLAG_STACK_EN
  cpu_flag_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .CLK      (CLK),
    .RST      (RST),
    .push_i   (PUSH),
    .pop_i    (POP),
    .din_i    (flags_q),
    .dout_o   (stk_dout),
    .pop_ok_o (pop_ok),
    .full_o   (STK_FULL),
    .empty_o  (STK_EMPTY),
    .err_o    (STK_ERR)
  );
`else
  logic unused_stk;
  assign unused_stk = PUSH ^ POP ^ (STACK_DEPTH < 2);
  assign stk_dout   = '0;
  assign pop_ok     = 1'b0;
  assign STK_FULL   = 1'b0;
  assign STK_EMPTY  = 1'b1;
  assign STK_ERR    = 1'b0;
`endif
  // the condition sees flags_d so a same-cycle update is forwarded into the evaluation
  always_comb begin
    flags_d     = pop_ok ? stk_dout : FLAG_CLR ? '0 : FLAG_WE ? {ALU_C, ALU_Z, ALU_B} : flags_q;
    state_d     = COND_REQ ? EVAL : IDLE;
    cond_true_d = COND_REQ & cond_eval(COND, flags_d);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q     <= '0;
      state_q     <= IDLE;
      cond_true_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      state_q     <= state_d;
      cond_true_q <= cond_true_d;
    end
  end
  assign C          = flags_q[IDX_C];
  assign Z          = flags_q[IDX_Z];
  assign B          = flags_q[IDX_B];
  assign COND_VALID = state_q == EVAL;
  assign COND_TRUE  = cond_true_q;
endmodule

// File: tb/tb_cpu_flag_ctrl.sv
// tb_cpu_flag_ctrl: directed self-checking bench for cpu_flag_ctrl (stack tests when CPU_FLAG_STACK_EN is defined)
module tb_cpu_flag_ctrl;
  logic CLK = 1'b0, RST, ALU_C, ALU_Z, ALU_B, FLAG_WE, FLAG_CLR, PUSH, POP, COND_REQ;
  logic [2:0] COND;
  logic C, Z, B, COND_VALID, COND_TRUE, STK_FULL, STK_EMPTY, STK_ERR;
  int checks = 0, errors = 0;
  cpu_flag_ctrl #(.STACK_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .ALU_C(ALU_C), .ALU_Z(ALU_Z), .ALU_B(ALU_B),
    .FLAG_WE(FLAG_WE), .FLAG_CLR(FLAG_CLR), .PUSH(PUSH), .POP(POP),
    .COND_REQ(COND_REQ), .COND(COND), .C(C), .Z(Z), .B(B),
    .COND_VALID(COND_VALID), .COND_TRUE(COND_TRUE),
    .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY), .STK_ERR(STK_ERR)
  );
  always #5 CLK = ~CLK;
  task automatic clr_in();
    RST = 0; {ALU_C, ALU_Z, ALU_B} = 3'b000; FLAG_WE = 0; FLAG_CLR = 0;
    PUSH = 0; POP = 0; COND_REQ = 0; COND = 3'b000;
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
    clr_in();
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [2:0] v);
    FLAG_WE = 1; {ALU_C, ALU_Z, ALU_B} = v;
    step();
  endtask
  logic [2:0] codes_exp;
  logic [7:0] tbl;
  initial begin
    clr_in();
    RST = 1;
    step();
    COND_REQ = 1; COND = 3'b000;
    step();
    chk("eval_always_valid", {3'b0, COND_VALID}, 4'h1);
    chk("eval_always_true", {3'b0, COND_TRUE}, 4'h1);
    RST = 1; COND_REQ = 1; PUSH = 1; FLAG_WE = 1; {ALU_C, ALU_Z, ALU_B} = 3'b111;
    step();
    chk("rst_flags", {1'b0, C, Z, B}, 4'h0);
    chk("rst_valid", {2'b0, COND_VALID, COND_TRUE}, 4'h0);
    chk("rst_stk", {1'b0, STK_FULL, STK_EMPTY, STK_ERR}, 4'b0010);
    ALU_Z = 1; FLAG_WE = 1; COND_REQ = 1; COND = 3'b001;
    step();
    chk("fwd_flags", {1'b0, C, Z, B}, 4'b0010);
    chk("fwd_cond", {2'b0, COND_VALID, COND_TRUE}, 4'b0011);
    COND_REQ = 1; COND = 3'b010;
    step();
    chk("b2b_cond", {2'b0, COND_VALID, COND_TRUE}, 4'b0010);
    step();
    chk("idle_cond", {2'b0, COND_VALID, COND_TRUE}, 4'b0000);
    load(3'b101);
    // expected truth per code for C=1 Z=0 B=1, code 7 down to 0
    tbl = 8'b0_0_1_0_1_1_0_1;
    for (int k = 0; k < 8; k++) begin
      COND_REQ = 1; COND = 3'(k);
      step();
      chk($sformatf("cond_%0d", k), {2'b0, COND_VALID, COND_TRUE}, {2'b0, 1'b1, tbl[k]});
    end
    FLAG_CLR = 1; FLAG_WE = 1; {ALU_C, ALU_Z, ALU_B} = 3'b111;
    step();
    chk("clr_over_we", {1'b0, C, Z, B}, 4'h0);
    load(3'b010);
    FLAG_CLR = 1; COND_REQ = 1; COND = 3'b010;
    step();
    chk("clr_fwd_cond", {2'b0, COND_VALID, COND_TRUE}, 4'b0011);
`ifdef CPU_FLAG_STACK_EN
    load(3'b101);
    PUSH = 1;
    step();
    chk("sr_push_empty", {3'b0, STK_EMPTY}, 4'h0);
    FLAG_CLR = 1;
    step();
    chk("sr_clr", {1'b0, C, Z, B}, 4'h0);
    POP = 1; FLAG_WE = 1; {ALU_C, ALU_Z, ALU_B} = 3'b010;
    step();
    chk("sr_pop_flags", {1'b0, C, Z, B}, 4'b0101);
    chk("sr_pop_empty", {3'b0, STK_EMPTY}, 4'h1);
    load(3'b001);
    for (int k = 0; k < 5; k++) begin
      PUSH = 1; FLAG_WE = 1; {ALU_C, ALU_Z, ALU_B} = 3'(k + 2);
      step();
      chk($sformatf("bnd_push%0d_full", k), {3'b0, STK_FULL}, {3'b0, k >= 3});
      chk($sformatf("bnd_push%0d_err", k), {3'b0, STK_ERR}, {3'b0, k == 4});
    end
    chk("bnd_flags_after_push", {1'b0, C, Z, B}, 4'h6);
    for (int k = 0; k < 5; k++) begin
      POP = 1;
      step();
      codes_exp = (k < 4) ? 3'(4 - k) : 3'd1;
      chk($sformatf("bnd_pop%0d_flags", k), {1'b0, C, Z, B}, {1'b0, codes_exp});
      chk($sformatf("bnd_pop%0d_empty", k), {3'b0, STK_EMPTY}, {3'b0, k >= 3});
      chk($sformatf("bnd_pop%0d_err", k), {3'b0, STK_ERR}, 4'h1);
    end
    RST = 1;
    step();
    chk("rst_err_clear", {3'b0, STK_ERR}, 4'h0);
    load(3'b011);
    PUSH = 1; FLAG_WE = 1; {ALU_C, ALU_Z, ALU_B} = 3'b110;
    step();
    PUSH = 1;
    step();
    PUSH = 1; POP = 1; FLAG_CLR = 1;
    step();
    chk("sim_flags", {1'b0, C, Z, B}, 4'h0);
    chk("sim_stk", {1'b0, STK_FULL, STK_EMPTY, STK_ERR}, 4'h0);
    POP = 1;
    step();
    chk("sim_pop1", {STK_EMPTY, C, Z, B}, 4'b0110);
    POP = 1;
    step();
    chk("sim_pop2", {STK_EMPTY, C, Z, B}, 4'b1011);
    chk("sim_err", {3'b0, STK_ERR}, 4'h0);
`else
    load(3'b101);
    PUSH = 1;
    step();
    chk("cfg_push_flags", {1'b0, C, Z, B}, 4'b0101);
    chk("cfg_push_stk", {1'b0, STK_FULL, STK_EMPTY, STK_ERR}, 4'b0010);
    POP = 1; FLAG_WE = 1; {ALU_C, ALU_Z, ALU_B} = 3'b010;
    step();
    chk("cfg_pop_we", {1'b0, C, Z, B}, 4'b0010);
    POP = 1;
    step();
    chk("cfg_pop_hold", {1'b0, C, Z, B}, 4'b0010);
    chk("cfg_pop_stk", {1'b0, STK_FULL, STK_EMPTY, STK_ERR}, 4'b0010);
    PUSH = 1; POP = 1; FLAG_CLR = 1;
    step();
    chk("cfg_both_clr", {1'b0, C, Z, B}, 4'h0);
    for (int k = 0; k < 4; k++) begin
      PUSH = 1;
      step();
    end
    chk("cfg_many_push", {1'b0, STK_FULL, STK_EMPTY, STK_ERR}, 4'b0010);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
